// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 read scheduler: state encoding, sensor
// timing constants at 25 MHz and the layout of the 32-bit reading.
package dht11_pkg;

  // Scheduler states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_GAP   = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_EVAL  = 3'd5,
    ST_RESP  = 3'd6
  } sched_state_t;

  // Sensor timing at a 25 MHz system clock
  localparam int unsigned DHT11_CLK_HZ        = 32'd25_000_000;
  localparam int unsigned DHT11_GAP_CYC       = 32'd50_000_000; // 2 s between reads
  localparam int unsigned DHT11_TIMEOUT_CYC   = 32'd625_000;    // 25 ms per read
  localparam int unsigned DHT11_START_LOW_CYC = 32'd450_000;    // 18 ms host low pulse
  localparam int unsigned DHT11_START_REL_CYC = 32'd750;        // 30 us host release
  localparam int unsigned DHT11_MAX_RETRY     = 32'd2;

  // Reading layout: {humidity, temperature}
  localparam int unsigned DHT11_HUM_W    = 32'd16;
  localparam int unsigned DHT11_TEMP_W   = 32'd16;
  localparam int unsigned DHT11_TEMP_OFS = 32'd0;
  localparam int unsigned DHT11_HUM_OFS  = DHT11_TEMP_OFS + DHT11_TEMP_W;
  localparam int unsigned DHT11_DATA_W   = DHT11_HUM_W + DHT11_TEMP_W;

endpackage

// File: rtl/dht11_read_scheduler_rr_arbiter.sv
// Round-robin arbiter for the DHT11 read scheduler. The grant is the first
// requester above the pointer (wrapping); the pointer moves to the winner
// only when update is asserted, so between updates it names the owner.
module rr_arbiter
  import dht11_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     update,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] ptr
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic             found;
  logic [PTR_W-1:0] win_idx;

  // Search upward from the pointer for the first active requester
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = ptr;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      int cand;
      cand = (int'(ptr) + k) % int'(N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        win_idx     = PTR_W'(cand);
        grant[cand] = 1'b1;
      end else begin
        found = found;
      end
    end
  end

  // Rotate the pointer onto the winner; reset value makes requester 0 win first
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PTR_W'(N_REQ - 32'd1);
    end else if (update && found) begin
      ptr <= win_idx;
    end
  end

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: shares one reader core between N_REQ requesters,
// enforces the inter-read gap, bounds each read with a timeout and retries
// failed reads. Optional feature macro: DHT11_SCHED_CACHE_EN (answer from the
// last good reading while the gap is still running).
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned MIN_GAP_CYC = DHT11_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = DHT11_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRY   = DHT11_MAX_RETRY
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic [DHT11_DATA_W-1:0] data_out,
  output logic                    err,
  output logic                    busy,
  output logic                    rd_start,
  input  logic                    rd_done,
  input  logic                    rd_valid,
  input  logic [DHT11_DATA_W-1:0] rd_data
);

  localparam int unsigned GAP_W   = $clog2(MIN_GAP_CYC + 32'd1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 32'd1);
  localparam int unsigned RETRY_W = (MAX_RETRY < 32'd1) ? 32'd1 : $clog2(MAX_RETRY + 32'd1);
  localparam int unsigned PTR_W   = $clog2(N_REQ);
  // The last WAIT cycle is TIMEOUT_CYC cycles after rd_start
  localparam logic [TMO_W-1:0] TMO_LOAD =
    TMO_W'((TIMEOUT_CYC > 32'd0) ? (TIMEOUT_CYC - 32'd1) : 32'd0);

  sched_state_t            state;
  sched_state_t            next_state;
  logic [GAP_W-1:0]        gap_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [RETRY_W-1:0]      retry_cnt;
  logic                    cap_valid;
  logic [DHT11_DATA_W-1:0] cap_data;
  logic [N_REQ-1:0]        gnt_next;
  logic [N_REQ-1:0]        ack_src;
  logic [N_REQ-1:0]        arb_grant;
  logic [PTR_W-1:0]        arb_ptr;
  logic                    arb_update;
  logic                    cache_hit;

  assign arb_update = (state == ST_ARB);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (arb_update),
    .grant  (arb_grant),
    .ptr    (arb_ptr)
  );

`ifdef DHT11_SCHED_CACHE_EN
  logic cache_valid;

  // Remember that a good reading is held in data_out
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else if (state == ST_EVAL && cap_valid) begin
      cache_valid <= 1'b1;
    end
  end

  assign cache_hit = cache_valid && (gap_cnt != '0);
`else
  assign cache_hit = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (|req) next_state = ST_ARB;
        else      next_state = ST_IDLE;
      end
      ST_ARB: begin
        if (!(|arb_grant)) next_state = ST_IDLE;
        else if (cache_hit) next_state = ST_RESP;
        else                next_state = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == '0) next_state = ST_START;
        else               next_state = ST_GAP;
      end
      ST_START: next_state = ST_WAIT;
      ST_WAIT: begin
        if (rd_done || (tmo_cnt == '0)) next_state = ST_EVAL;
        else                            next_state = ST_WAIT;
      end
      ST_EVAL: begin
        if (cap_valid)                          next_state = ST_RESP;
        else if (retry_cnt < RETRY_W'(MAX_RETRY)) next_state = ST_GAP;
        else                                    next_state = ST_RESP;
      end
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Owner bookkeeping: grant latched in ARB, cleared after RESP; the
  // acknowledged requester is the arbiter pointer, which names the owner
  always_comb begin
    gnt_next = gnt;
    ack_src  = N_REQ'(1) << arb_ptr;
    case (state)
      ST_ARB: begin
        gnt_next = arb_grant;
        ack_src  = arb_grant;
      end
      ST_RESP: gnt_next = '0;
      default: gnt_next = gnt;
    endcase
  end

  // State, registered outputs and datapath counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      ack       <= '0;
      rd_start  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      data_out  <= '0;
      gap_cnt   <= GAP_W'(MIN_GAP_CYC);
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      state    <= next_state;
      gnt      <= gnt_next;
      busy     <= (next_state != ST_IDLE);
      rd_start <= (next_state == ST_START);
      ack      <= (next_state == ST_RESP) ? ack_src : '0;

      // Gap restarts when a read attempt ends, then counts down to 0
      if (state == ST_WAIT && next_state == ST_EVAL) begin
        gap_cnt <= GAP_W'(MIN_GAP_CYC);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      // Per-attempt timeout
      if (state == ST_START) begin
        tmo_cnt <= TMO_LOAD;
      end else if (state == ST_WAIT && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TMO_W'(1);
      end

      // Capture the reader result; a timeout counts as a failed read
      if (state == ST_WAIT) begin
        if (rd_done) begin
          cap_valid <= rd_valid;
          cap_data  <= rd_data;
        end else if (tmo_cnt == '0) begin
          cap_valid <= 1'b0;
        end
      end

      // Retry count per transaction
      if (state == ST_ARB) begin
        retry_cnt <= '0;
      end else if (state == ST_EVAL && next_state == ST_GAP) begin
        retry_cnt <= retry_cnt + RETRY_W'(1);
      end

      // Result: good read updates data, exhausted retries flag err,
      // cache hit keeps data and clears err
      if (state == ST_EVAL && next_state == ST_RESP) begin
        if (cap_valid) begin
          data_out <= cap_data;
          err      <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else if (state == ST_ARB && next_state == ST_RESP) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed self-checking bench for dht11_read_scheduler (gap 100, timeout 50,
// two retries). Cache-enabled expectations apply when DHT11_SCHED_CACHE_EN
// is defined.
module tb_dht11_read_scheduler;

  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt;
  logic [NR-1:0] ack;
  logic [31:0]   data_out;
  logic          err;
  logic          busy;
  logic          rd_start;
  logic          rd_done;
  logic          rd_valid;
  logic [31:0]   rd_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int            start_cnt = 0;
  int            last_start_cyc = 0;
  int            ack_cnt = 0;
  int            last_ack_cyc = 0;
  logic [NR-1:0] last_ack = '0;
  logic [31:0]   last_ack_data = '0;
  logic          last_ack_err = 1'b0;

  dht11_read_scheduler #(
    .N_REQ       (NR),
    .MIN_GAP_CYC (100),
    .TIMEOUT_CYC (50),
    .MAX_RETRY   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .ack      (ack),
    .data_out (data_out),
    .err      (err),
    .busy     (busy),
    .rd_start (rd_start),
    .rd_done  (rd_done),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (rd_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
    end
    if (ack !== '0) begin
      ack_cnt++;
      last_ack_cyc  = cyc;
      last_ack      = ack;
      last_ack_data = data_out;
      last_ack_err  = err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rd_done = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit ok, output int sc);
    int n0;
    n0 = start_cnt; ok = 1'b0; sc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (start_cnt != n0) begin
        ok = 1'b1; sc = last_start_cyc; break;
      end
    end
  endtask

  // Reader model: answer a rd_start after 'dly' cycles
  task automatic serve(input int dly, input logic v, input logic [31:0] d,
                       output bit ok, output int sc, output int dc);
    wait_start(300, ok, sc);
    dc = 0;
    if (ok) begin
      repeat (dly) tick();
      rd_done = 1'b1; rd_valid = v; rd_data = d; dc = cyc;
      tick();
      rd_done = 1'b0; rd_valid = 1'b0; rd_data = '0;
    end
  endtask

  task automatic wait_ack(input int budget, output bit ok);
    int n0;
    n0 = ack_cnt; ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (ack_cnt != n0) begin
        ok = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({gnt, ack, rd_start, busy, err} !== '0) begin bad++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, ack, rd_start, busy, err}); end
    total++; if (data_out !== 32'h0) begin bad++;
      $display("FAIL reset_data: got %h want 0", data_out); end
  endtask

  task automatic test_first_read();
    bit ok; int t0, sc, dc, a0;
    do_reset();
    req = 2'b01; t0 = cyc; a0 = ack_cnt;
    tick();
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL t1_gnt_early: got %b want 00", gnt); end
    tick();
    total++; if (gnt !== 2'b01 || busy !== 1'b1) begin bad++;
      $display("FAIL t1_gnt: got gnt=%b busy=%b want 01/1", gnt, busy); end
    repeat (8) tick();
    // stray completion while not waiting must be ignored
    rd_done = 1'b1; rd_valid = 1'b1; rd_data = 32'hFFFF_FFFF;
    tick();
    rd_done = 1'b0; rd_valid = 1'b0; rd_data = '0;
    serve(5, 1'b1, 32'h3700_1900, ok, sc, dc);
    total++; if (!ok || (sc - t0) < 100) begin bad++;
      $display("FAIL t1_start_gap: got ok=%0d at=%0d want >=100", ok, sc - t0); end
    wait_ack(10, ok);
    req = 2'b00;
    total++; if (!ok || last_ack !== 2'b01 || (last_ack_cyc - dc) != 2) begin bad++;
      $display("FAIL t1_ack: got ok=%0d ack=%b lat=%0d want 01 lat 2", ok, last_ack, last_ack_cyc - dc); end
    total++; if (last_ack_data !== 32'h3700_1900 || last_ack_err !== 1'b0) begin bad++;
      $display("FAIL t1_data: got %h err=%b want 37001900 err=0", last_ack_data, last_ack_err); end
    total++; if (ack !== 2'b00 || (ack_cnt - a0) != 1) begin bad++;
      $display("FAIL t1_ack_pulse: got ack=%b n=%0d want 00 n=1", ack, ack_cnt - a0); end
  endtask

  task automatic test_round_robin();
    bit ok; int sc, dc, prev_dc;
    logic [NR-1:0] exp_ack;
    do_reset();
    req = 2'b11;
    prev_dc = cyc - 100;
    for (int i = 0; i < 3; i++) begin
      exp_ack = (i == 1) ? 2'b10 : 2'b01;
      serve(4, 1'b1, 32'h4000_2000 + i, ok, sc, dc);
      total++; if (!ok || (sc - prev_dc) < 100) begin bad++;
        $display("FAIL t2_gap%0d: got ok=%0d gap=%0d want >=100", i, ok, sc - prev_dc); end
      wait_ack(10, ok);
      total++; if (!ok || last_ack !== exp_ack || last_ack_data !== (32'h4000_2000 + i)) begin bad++;
        $display("FAIL t2_ack%0d: got ack=%b data=%h want %b", i, last_ack, last_ack_data, exp_ack); end
      prev_dc = dc;
    end
    req = 2'b00;
  endtask

  task automatic test_retry();
    bit ok; int sc, dc, prev_dc, s0, a0;
    do_reset();
    req = 2'b01; s0 = start_cnt; a0 = ack_cnt;
    prev_dc = cyc - 100;
    for (int i = 0; i < 3; i++) begin
      serve(6, (i == 2), (i == 2) ? 32'h1234_5678 : 32'hDEAD_BEEF, ok, sc, dc);
      total++; if (!ok || (sc - prev_dc) < 100) begin bad++;
        $display("FAIL t3_gap%0d: got ok=%0d gap=%0d want >=100", i, ok, sc - prev_dc); end
      prev_dc = dc;
    end
    wait_ack(10, ok);
    req = 2'b00;
    repeat (5) tick();
    total++; if (!ok || last_ack_err !== 1'b0 || last_ack_data !== 32'h1234_5678) begin bad++;
      $display("FAIL t3_ack: got ok=%0d err=%b data=%h want 0/12345678", ok, last_ack_err, last_ack_data); end
    total++; if ((start_cnt - s0) != 3 || (ack_cnt - a0) != 1) begin bad++;
      $display("FAIL t3_counts: got starts=%0d acks=%0d want 3/1", start_cnt - s0, ack_cnt - a0); end
  endtask

  task automatic test_timeout();
    bit ok; int sc [3];
    repeat (100) tick();
    req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      wait_start(300, ok, sc[i]);
      total++; if (!ok || (i > 0 && (sc[i] - sc[i-1]) < 150)) begin bad++;
        $display("FAIL t4_start%0d: got ok=%0d spacing=%0d want >=150", i, ok, (i > 0) ? sc[i] - sc[i-1] : 0); end
    end
    wait_ack(80, ok);
    req = 2'b00;
    total++; if (!ok || last_ack !== 2'b10 || (last_ack_cyc - sc[2]) != 52) begin bad++;
      $display("FAIL t4_ack: got ok=%0d ack=%b lat=%0d want 10 lat 52", ok, last_ack, last_ack_cyc - sc[2]); end
    total++; if (last_ack_err !== 1'b1 || last_ack_data !== 32'h1234_5678) begin bad++;
      $display("FAIL t4_err: got err=%b data=%h want 1/12345678", last_ack_err, last_ack_data); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int sc, s0, a0;
    req = 2'b01;
    wait_start(300, ok, sc);
    total++; if (!ok) begin bad++; $display("FAIL t5_start: got none want rd_start"); end
    repeat (2) tick();
    rst = 1'b1; req = 2'b00;
    tick();
    rst = 1'b0; s0 = start_cnt; a0 = ack_cnt;
    total++; if ({gnt, ack, rd_start, busy, err} !== '0 || data_out !== 32'h0) begin bad++;
      $display("FAIL t5_after_rst: got ctl=%b data=%h want 0", {gnt, ack, rd_start, busy, err}, data_out); end
    repeat (3) tick();
    rd_done = 1'b1; rd_valid = 1'b1; rd_data = 32'hAAAA_5555;
    tick();
    rd_done = 1'b0; rd_valid = 1'b0; rd_data = '0;
    repeat (10) tick();
    total++; if ((ack_cnt - a0) != 0 || (start_cnt - s0) != 0 || busy !== 1'b0 || data_out !== 32'h0) begin bad++;
      $display("FAIL t5_late_done: got acks=%0d starts=%0d busy=%b data=%h want 0", ack_cnt - a0, start_cnt - s0, busy, data_out); end
  endtask

  task automatic test_cache();
    bit ok; int sc, dc, r, s0, a0;
    req = 2'b01;
    serve(3, 1'b1, 32'h2A00_1600, ok, sc, dc);
    wait_ack(10, ok);
    req = 2'b00;
    total++; if (!ok || last_ack_data !== 32'h2A00_1600) begin bad++;
      $display("FAIL t6_fill: got ok=%0d data=%h want 2a001600", ok, last_ack_data); end
    repeat (20) tick();
    req = 2'b10; r = cyc; s0 = start_cnt; a0 = ack_cnt;
`ifdef DHT11_SCHED_CACHE_EN
    wait_ack(5, ok);
    req = 2'b00;
    total++; if (!ok || last_ack !== 2'b10 || (last_ack_cyc - r) > 3) begin bad++;
      $display("FAIL t6_hit_ack: got ok=%0d ack=%b lat=%0d want 10 lat<=3", ok, last_ack, last_ack_cyc - r); end
    total++; if (last_ack_data !== 32'h2A00_1600 || last_ack_err !== 1'b0 || start_cnt != s0) begin bad++;
      $display("FAIL t6_hit_data: got data=%h err=%b starts=%0d want 2a001600/0/0", last_ack_data, last_ack_err, start_cnt - s0); end
`else
    repeat (5) tick();
    total++; if (ack_cnt != a0) begin bad++;
      $display("FAIL t6_no_early_ack: got %0d acks want 0", ack_cnt - a0); end
    serve(3, 1'b1, 32'h2B00_1700, ok, sc, dc);
    total++; if (!ok || (sc - (dc - 3 - 1)) < 0 || (sc - r) < 70) begin bad++;
      $display("FAIL t6_miss_start: got ok=%0d after_req=%0d want >=70", ok, sc - r); end
    wait_ack(10, ok);
    req = 2'b00;
    total++; if (!ok || last_ack !== 2'b10 || last_ack_data !== 32'h2B00_1700 || (start_cnt - s0) != 1) begin bad++;
      $display("FAIL t6_miss_ack: got ack=%b data=%h starts=%0d want 10/2b001700/1", last_ack, last_ack_data, start_cnt - s0); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_round_robin();
    test_retry();
    test_timeout();
    test_reset_mid_wait();
    test_cache();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
